// File: rtl/montgomery_to_conv.sv
// -----------------------------------------------------------------------------
// montgomery_to_conv
//
// Converts a conventional-domain operand into the Montgomery domain by
// computing y = (a * 2^m_size) mod m with one modular doubling per clock.
// The working value x doubles each step. When the doubled value reaches or
// exceeds the modulus, the modulus is subtracted. Because x < m holds at
// every step, a single conditional subtraction is enough to keep x reduced.
//
// Parameters
//   NBITS      operand / modulus width in bits
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enable_p   single-cycle start pulse (only accepted while idle)
//   a          conventional-domain operand, expected a < m
//   m          modulus, expected odd and > 1
//   m_size     exponent k of R = 2^k (0..4095)
//   y          registered result, held between completions
//   busy       high while a conversion is running or completing
//   done_irq_p single-cycle completion pulse, aligned with y updating
//
// Timing
//   The edge that samples enable_p loads the operands. Each following
//   edge performs one doubling step. y updates and done_irq_p rises on
//   the edge that performs the last step, so the edge that samples
//   enable_p plus m_size further edges span m_size+1 edges in total.
//   With m_size = 0, the sampling edge itself loads y with a and
//   raises done_irq_p.
// -----------------------------------------------------------------------------
module montgomery_to_conv #(
    parameter int NBITS = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] m,
    input  logic [11:0]      m_size,
    output logic [NBITS-1:0] y,
    output logic             busy,
    output logic             done_irq_p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [11:0]      cnt;
    logic [NBITS-1:0] x;
    logic [NBITS-1:0] m_r;
    logic [NBITS-1:0] x_dbl;
    logic             start;
    logic             last_step;

    // One modular doubling step. The doubled value carries one extra bit
    // so that 2*v cannot overflow before it is compared with the modulus.
    function automatic logic [NBITS-1:0] mod_double(
        input logic [NBITS-1:0] v,
        input logic [NBITS-1:0] md
    );
        logic [NBITS:0] d;
        d = {v, 1'b0};
        if (d >= {1'b0, md}) begin
            d = d - {1'b0, md};
        end
        return d[NBITS-1:0];
    endfunction

    assign x_dbl     = mod_double(x, m_r);
    assign start     = (state == IDLE) && enable_p;
    assign last_step = (state == RUN) && (cnt == 12'd1);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable_p) begin
                    state_nxt = (m_size == 12'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == 12'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The DONE state always lasts one cycle. A start request in
                // this cycle is dropped, so a new start is accepted only from IDLE.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Status outputs. These are registered from the next state so that they
    // come straight off flops and do not glitch from state decoding.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done_irq_p <= 1'b0;
        end else begin
            busy       <= (state_nxt != IDLE);
            done_irq_p <= (state_nxt == DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: operand latch, step counter, working value and result
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 12'd0;
            x   <= '0;
            m_r <= '0;
            y   <= '0;
        end else begin
            if (start) begin
                x   <= a;
                m_r <= m;
                cnt <= m_size;
                // With no doubling steps, the operand itself is the result.
                if (m_size == 12'd0) begin
                    y <= a;
                end
            end else if (state == RUN) begin
                x   <= x_dbl;
                cnt <= cnt - 12'd1;
                // y only changes on the final step and is held otherwise.
                if (last_step) begin
                    y <= x_dbl;
                end
            end
        end
    end

endmodule

// File: tb/tb_montgomery_to_conv.sv
// -----------------------------------------------------------------------------
// tb_montgomery_to_conv
//
// Bench for montgomery_to_conv. One 8-bit instance covers the functional
// scenarios. One 2048-bit instance covers the full-width conversion.
// Expected results come from plain modular arithmetic on (a << k) mod m.
// -----------------------------------------------------------------------------
module tb_montgomery_to_conv;

    localparam int NB = 8;
    localparam int NW = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           enable_p;
    logic [NB-1:0]  a;
    logic [NB-1:0]  m;
    logic [11:0]    m_size;
    logic [NB-1:0]  y;
    logic           busy;
    logic           done_irq_p;

    logic           enable_w;
    logic [NW-1:0]  a_w;
    logic [NW-1:0]  m_w;
    logic [11:0]    ms_w;
    logic [NW-1:0]  y_w;
    logic           busy_w;
    logic           done_w;

    int errors = 0;
    int checks = 0;

    montgomery_to_conv #(.NBITS(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_p   (enable_p),
        .a          (a),
        .m          (m),
        .m_size     (m_size),
        .y          (y),
        .busy       (busy),
        .done_irq_p (done_irq_p)
    );

    montgomery_to_conv #(.NBITS(NW)) dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_p   (enable_w),
        .a          (a_w),
        .m          (m_w),
        .m_size     (ms_w),
        .y          (y_w),
        .busy       (busy_w),
        .done_irq_p (done_w)
    );

    // Reference: (a * 2^k) mod m with plain integer arithmetic (k <= 40 here).
    function automatic logic [NB-1:0] ref_conv(input logic [NB-1:0] av,
                                               input logic [NB-1:0] mv,
                                               input int k);
        longint p;
        p = longint'(av) << k;
        return NB'(p % longint'(mv));
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        enable_p = 1'b0;
        a        = '0;
        m        = 8'd13;
        m_size   = '0;
        enable_w = 1'b0;
        a_w      = '0;
        m_w      = '0;
        ms_w     = '0;
        #3;
        checks++;
        if (y !== 8'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", y); end
        checks++;
        if (busy !== 1'b0 || done_irq_p !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done_irq_p);
        end
        checks++;
        if (y_w !== '0 || busy_w !== 1'b0 || done_w !== 1'b0) begin
            errors++; $display("FAIL reset_wide got busy=%b done=%b y_lo=%h exp zeros", busy_w, done_w, y_w[63:0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (y !== 8'd0 || busy !== 1'b0 || done_irq_p !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got y=%0d busy=%b done=%b exp 0 0 0", y, busy, done_irq_p);
        end
    endtask

    // Runs one conversion and checks latency, result, busy and y stability.
    task automatic run_check(input string name, input logic [NB-1:0] av,
                             input logic [NB-1:0] mv, input int k);
        logic [NB-1:0] exp_y;
        logic [NB-1:0] y_prev;
        int n;
        int busy_bad;
        int y_bad;
        exp_y  = ref_conv(av, mv, k);
        y_prev = y;
        @(negedge clk);
        a        = av;
        m        = mv;
        m_size   = 12'(k);
        enable_p = 1'b1;
        @(posedge clk);
        #1;
        enable_p = 1'b0;
        // Inputs wander after the start edge; the running conversion must ignore them.
        a        = NB'($urandom);
        m        = NB'($urandom);
        m_size   = 12'($urandom);
        n        = 0;
        busy_bad = 0;
        y_bad    = 0;
        while (done_irq_p !== 1'b1 && n < k + 10) begin
            if (busy !== 1'b1) busy_bad++;
            if (y !== y_prev) y_bad++;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != k) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d edges after start", name, n, k); end
        checks++;
        if (y !== exp_y) begin errors++; $display("FAIL %s_y got=%0d exp=%0d", name, y, exp_y); end
        checks++;
        if (busy_bad != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s_busy got low_cycles=%0d busy_at_done=%b exp 0 1", name, busy_bad, busy);
        end
        checks++;
        if (y_bad != 0) begin errors++; $display("FAIL %s_y_hold got changes=%0d exp=0", name, y_bad); end
        @(posedge clk);
        #1;
        checks++;
        if (done_irq_p !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_after got done=%b busy=%b exp 0 0", name, done_irq_p, busy);
        end
    endtask

    task automatic test_vectors();
        run_check("v5_13_4", 8'd5, 8'd13, 4);
        run_check("v12_13_4", 8'd12, 8'd13, 4);
        run_check("v0_13_8", 8'd0, 8'd13, 8);
        run_check("v7_13_0", 8'd7, 8'd13, 0);
    endtask

    task automatic test_random();
        logic [NB-1:0] mv;
        logic [NB-1:0] av;
        int k;
        for (int i = 0; i < 8; i++) begin
            mv = NB'($urandom_range(3, 255)) | 8'd1;
            av = NB'($urandom_range(0, int'(mv) - 1));
            k  = (i == 0) ? 0 : int'($urandom_range(1, 20));
            run_check($sformatf("rnd%0d", i), av, mv, k);
        end
    endtask

    // Start requests while running and during the completion cycle are ignored.
    task automatic test_ignore_enable();
        int ndone;
        @(negedge clk);
        a = 8'd5; m = 8'd13; m_size = 12'd4; enable_p = 1'b1;
        @(posedge clk);                    // edge 1 samples the start
        #1;
        enable_p = 1'b0;
        ndone = 0;
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            enable_p = (i == 2 || i == 5 || i == 6);
            a = 8'd9; m = 8'd11; m_size = 12'd1;
            @(posedge clk);
            #1;
            enable_p = 1'b0;
            if (done_irq_p === 1'b1) ndone++;
            if (i == 5) begin
                checks++;
                if (done_irq_p !== 1'b1 || y !== 8'd2) begin
                    errors++; $display("FAIL ign_first got done=%b y=%0d exp 1 2", done_irq_p, y);
                end
            end
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL ign_pulses got=%0d exp=1", ndone); end
        checks++;
        if (y !== 8'd2 || busy !== 1'b0) begin
            errors++; $display("FAIL ign_hold got y=%0d busy=%b exp 2 0", y, busy);
        end
    endtask

    // Reset in the middle of a run aborts it; a fresh run then works.
    task automatic test_reset_abort();
        int ndone;
        @(negedge clk);
        a = 8'd12; m = 8'd13; m_size = 12'd4; enable_p = 1'b1;
        @(posedge clk);                    // edge 1
        #1;
        enable_p = 1'b0;
        @(posedge clk);                    // edge 2
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 8'd0 || busy !== 1'b0 || done_irq_p !== 1'b0) begin
            errors++; $display("FAIL abort_async got y=%0d busy=%b done=%b exp 0 0 0", y, busy, done_irq_p);
        end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin @(negedge clk); rst_n = 1'b1; end
            @(posedge clk);
            #1;
            if (done_irq_p === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_nodone got pulses=%0d busy=%b exp 0 0", ndone, busy);
        end
        run_check("after_abort", 8'd12, 8'd13, 4);
    endtask

    // Full-width conversion against (a << 2048) mod m.
    task automatic test_wide();
        logic [2*NW-1:0] prod;
        logic [2*NW-1:0] mm;
        logic [NW-1:0]   exp_y;
        int n;
        for (int i = 0; i < NW / 32; i++) begin
            m_w[i*32 +: 32] = $urandom;
            a_w[i*32 +: 32] = $urandom;
        end
        m_w[0]      = 1'b1;
        m_w[NW-1]   = 1'b1;
        a_w         = a_w % m_w;
        prod        = {a_w, {NW{1'b0}}};
        mm          = {{NW{1'b0}}, m_w};
        prod        = prod % mm;
        exp_y       = prod[NW-1:0];
        @(negedge clk);
        ms_w     = 12'd2048;
        enable_w = 1'b1;
        @(posedge clk);
        #1;
        enable_w = 1'b0;
        a_w      = '0;
        n        = 0;
        while (done_w !== 1'b1 && n < NW + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != NW) begin errors++; $display("FAIL wide_latency got=%0d exp=%0d edges after start", n, NW); end
        checks++;
        if (y_w !== exp_y) begin
            errors++; $display("FAIL wide_y got_lo=%h exp_lo=%h", y_w[63:0], exp_y[63:0]);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_ignore_enable();
        test_reset_abort();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
